lzc_norm_pipe: RTL and testbench
================================

# lzc_norm_pipe

Pipelined, parametrised leading-zero / leading-sign counter and normaliser with valid/ready handshaking. It takes a W-bit fixed-point word and returns three results: the count, the word left-shifted by that count, and a degenerate-input flag. Unsigned and signed mode are selectable per transaction. It sits between the ray-stepping arithmetic and the reciprocal/divider path, where it replaces the single-width combinational counter so that any Qm.n width can be normalised at full clock rate.

## Interface
Parameters:
- `W`, default 20: data width (Qm+Qn). Legal range is 4..32.
- `CW`, derived localparam `$clog2(W+1)`: count width (5 for W=20).

Ports (clock and reset first):
- `clk`  in  1: single clock, rising-edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `i_data`  in  W: input word.
- `i_signed`  in  1: 1 selects leading-sign-bit count; 0 selects leading-zero count.
- `i_valid`  in  1: input word is valid.
- `o_ready`  out  1: block can accept an input this cycle.
- `o_count`  out  CW: result count.
- `o_norm`  out  W: `i_data` shifted left by `o_count`, zero-filled, truncated to W bits.
- `o_zero`  out  1: degenerate input (all zeros in unsigned mode; all bits equal to the MSB in signed mode).
- `o_valid`  out  1: result outputs are valid.
- `i_ready`  in  1: downstream accepts the result.

## Operation
Unsigned mode (`i_signed`=0):
- `o_count` = number of leading zeros, range 0..W.
- Zero input gives `o_count`=W, `o_norm`=0, `o_zero`=1.

Signed mode (`i_signed`=1):
- `o_count` = (number of leading bits equal to MSB) − 1, range 0..W−1.
- `o_norm` has bit W−1 ≠ bit W−2 unless `o_zero`=1.
- All-zeros input gives count W−1, norm 0, zero 1.
- All-ones input gives count W−1, norm 1 followed by W−1 zeros, zero 1.

Pipeline structure:
- Two register stages, S1 and S2.
- S1 captures the data and mode, plus a coarse count of leading 4-bit groups.
- S2 computes the fine count and the barrel shift, and holds the outputs.
- Each stage has a valid bit.
- S2 loads when `!s2_valid || i_ready`.
- S1 loads when `!s1_valid || S2 loads`.
- `o_ready` = `!s1_valid || S2 loads` (combinational from `i_ready`; no path from `i_valid`).

Handshake rules:
- Transfer in occurs when `i_valid && o_ready` at a rising edge.
- Transfer out occurs when `o_valid && i_ready` at a rising edge.
- Results emerge in input order, with no drops and no duplication.
- While `o_valid && !i_ready`, all outputs hold stable.
- Data registers update only on a stage load. Bubbles do not modify S2 data outputs.

Arithmetic rules:
- Shift amount equals `o_count`.
- Shifted-out high bits are discarded.
- All arithmetic is unsigned on the CW-bit count.

## Timing
Reset:
- `reset_n` low asynchronously clears s1_valid, s2_valid, `o_valid`, `o_count`, `o_norm` and `o_zero` to 0.
- `o_ready` reads 1 during and after reset.
- Reset mid-stream discards all in-flight items. The first valid result after release comes only from a post-reset input.

Latency and throughput:
- Latency is 2 cycles. An input accepted at edge k gives `o_valid`=1 after edge k+1 when no stall is present.
- Throughput is one result per cycle with `i_ready` held high.

Backpressure:
- With `i_ready` low, the block absorbs at most 2 items. `o_ready` falls after the second acceptance.
- When `i_ready` is raised, `o_ready` returns to 1 in the same cycle (full-pipeline advance).
- Simultaneous out-transfer and in-transfer on a full pipeline is legal and loses no data.

## Test plan
- **Unsigned sweep, W=20, `i_ready`=1:**
  - 0x80000 → count 0, norm 0x80000.
  - 0x00001 → count 19, norm 0x80000.
  - 0x00123 → count 11, norm 0x91800.
  - 0x00000 → count 20, norm 0, zero 1.
  - Each result arrives 2 cycles after acceptance.
- **Signed mode, W=20:**
  - 0x00123 → count 10, norm 0x48C00.
  - 0xFFC00 → count 9, norm 0x80000, zero 0.
  - 0xFFFFF → count 19, norm 0x80000, zero 1.
  - 0x00000 → count 19, norm 0, zero 1.
- **Back-to-back stream:** 16 random words with mixed `i_signed` values, `i_valid` and `i_ready` held at 1 → 16 results on consecutive cycles, matching the model, in order.
- **Backpressure:**
  - Stimulus: feed 4 words; `i_ready` low for 3 cycles after the first result.
  - Required: `o_ready` drops after 2 acceptances and outputs hold stable while stalled.
  - Required after release: all 4 results arrive in order with none lost.
- **Reset mid-operation:** assert `reset_n`=0 with both stages full → `o_valid`=0 and outputs 0 immediately (asynchronously). After release, a single input 0x00040 gives count 13, norm 0x80000 two cycles after acceptance, with no stale result.
- **Width generality:** repeat the random-stream check for W=4, 17, 24 and 32 (with CW = 3, 5, 5 and 6 respectively) → all counts and norms match the model, including zero and all-ones inputs.

Source files
------------

// File: rtl/lzc_norm_pipe.sv
// Two-stage leading-zero / leading-sign counter and normaliser.
// S1 captures the word plus a coarse 4-bit-group count; S2 finishes the count and shifts.

module lzc_norm_grp (
  input  logic [3:0] nib,
  output logic [1:0] lz
);
  // Only meaningful for a non-zero nibble; an all-zero group is resolved by the coarse count.
  always_comb begin
    if (nib[3])      lz = 2'd0;
    else if (nib[2]) lz = 2'd1;
    else if (nib[1]) lz = 2'd2;
    else             lz = 2'd3;
  end
endmodule

module lzc_norm_pipe #(
  parameter  int W  = 20,
  localparam int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [W-1:0]  i_data,
  input  logic          i_signed,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [CW-1:0] o_count,
  output logic [W-1:0]  o_norm,
  output logic          o_zero,
  output logic          o_valid,
  input  logic          i_ready
);
  localparam int GW     = (W + 3) / 4;
  localparam int WP     = 4 * GW;
  localparam int CGW    = $clog2(GW + 1);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [W-1:0]   data;
    logic [WP-1:0]  key;
    logic [CGW-1:0] cg;
    logic           zero;
  } s1_t;

  typedef struct packed {
    logic [CW-1:0] count;
    logic [W-1:0]  norm;
    logic          zero;
  } s2_t;

  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  s1_t             s1_q, s1_d;
  s2_t             s2_q, s2_d;

  logic s1_load, s2_load;

  // ---------------- S1 input side: key word and coarse group count
  logic [W-1:0]   key_w;
  logic [WP-1:0]  key_p;
  logic [GW-1:0]  grp_z;
  logic           in_zero;
  logic [CGW-1:0] cg_cnt;
  logic           cg_run;

  // Signed mode counts sign-bit transitions: adjacent-bit XOR with a forced
  // trailing 1 turns "leading bits equal to MSB minus one" into a plain LZC.
  always_comb begin
    if (i_signed) key_w = {i_data[W-2:0] ^ i_data[W-1:1], 1'b1};
    else          key_w = i_data;
    key_p   = WP'(key_w) << (WP - W);
    in_zero = i_signed ? ~|key_w[W-1:1] : ~|i_data;
    for (int g = 0; g < GW; g++) grp_z[g] = ~|key_p[WP-1-4*g -: 4];
    cg_cnt = '0;
    cg_run = 1'b1;
    for (int g = 0; g < GW; g++) begin
      if (cg_run && grp_z[g]) cg_cnt = cg_cnt + CGW'(1);
      else                    cg_run = 1'b0;
    end
  end

  // ---------------- S2 input side: fine count and barrel shift
  logic [GW-1:0][1:0] grp_lz;
  logic [1:0]         fine;
  logic [CW+1:0]      raw;
  logic [CW-1:0]      count_c;
  logic [W-1:0]       norm_c;

  for (genvar g = 0; g < GW; g++) begin : g_grp
    lzc_norm_grp u_grp (
      .nib (s1_q.key[WP-1-4*g -: 4]),
      .lz  (grp_lz[g])
    );
  end

  // Padding groups can push the raw count past W for a zero input; clamp it.
  always_comb begin
    fine = 2'd0;
    for (int g = 0; g < GW; g++) begin
      if (CGW'(g) == s1_q.cg) fine = grp_lz[g];
    end
    raw     = ((CW + 2)'(s1_q.cg) << 2) + (CW + 2)'(fine);
    count_c = (raw > (CW + 2)'(W)) ? CW'(W) : raw[CW-1:0];
    norm_c  = s1_q.data << count_c;
  end

  // ---------------- handshake and stage loads
  assign s2_load = !vld_pipe_q[2] || i_ready;
  assign s1_load = !vld_pipe_q[1] || s2_load;
  assign o_ready = s1_load;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    if (s1_load) vld_pipe_d[1] = i_valid;
    if (s1_load && i_valid) begin
      s1_d.data = i_data;
      s1_d.key  = key_p;
      s1_d.cg   = cg_cnt;
      s1_d.zero = in_zero;
    end
    if (s2_load) vld_pipe_d[2] = vld_pipe_q[1];
    if (s2_load && vld_pipe_q[1]) begin
      s2_d.count = count_c;
      s2_d.norm  = norm_c;
      s2_d.zero  = s1_q.zero;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign o_valid = vld_pipe_q[2];
  assign o_count = s2_q.count;
  assign o_norm  = s2_q.norm;
  assign o_zero  = s2_q.zero;

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Bench for lzc_norm_pipe: directed W=20 vectors plus random streams at W=4/17/24/32,
// all results scored against a bit-walking reference model.

module tb_lzc_norm_pipe;
  typedef struct {
    int          c;
    logic [31:0] n;
    bit          z;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [19:0] d0;
  logic        s0, v0, r0, rst0;
  logic        rdy0, vld0, zr0;
  logic [4:0]  cnt0;
  logic [19:0] nrm0;
  int          rx0;
  logic [4:0]  done_v;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Walk from the MSB counting bits equal to the reference (0, or the MSB when signed).
  function automatic exp_t model(input logic [31:0] d, input bit s, input int w);
    exp_t        e;
    int          run;
    bit          ref_b, going;
    logic [31:0] mask;
    ref_b = s ? d[w-1] : 1'b0;
    run   = 0;
    going = 1'b1;
    for (int i = w - 1; i >= 0; i--) begin
      if (going && d[i] == ref_b) run++;
      else going = 1'b0;
    end
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    e.c  = s ? run - 1 : run;
    e.n  = (d << e.c) & mask;
    e.z  = (run == w);
    return e;
  endfunction

  for (genvar g = 0; g < 5; g++) begin : g_w
    localparam int WX  = (g == 0) ? 20 : (g == 1) ? 4 : (g == 2) ? 17 : (g == 3) ? 24 : 32;
    localparam int CWX = $clog2(WX + 1);

    logic [WX-1:0]  din;
    logic           sgn, vin, rin, rstn;
    logic           rdy, vout, zr;
    logic [CWX-1:0] cnt;
    logic [WX-1:0]  nrm;
    logic           done;
    int             rx = 0;
    exp_t           eq[$];

    lzc_norm_pipe #(.W(WX)) u_dut (
      .clk      (clk),
      .reset_n  (rstn),
      .i_data   (din),
      .i_signed (sgn),
      .i_valid  (vin),
      .o_ready  (rdy),
      .o_count  (cnt),
      .o_norm   (nrm),
      .o_zero   (zr),
      .o_valid  (vout),
      .i_ready  (rin)
    );

    assign done_v[g] = done;

    if (g == 0) begin : g_tie
      assign din  = d0;
      assign sgn  = s0;
      assign vin  = v0;
      assign rin  = r0;
      assign rstn = rst0;
      assign rdy0 = rdy;
      assign vld0 = vout;
      assign zr0  = zr;
      assign cnt0 = cnt;
      assign nrm0 = nrm;
      assign rx0  = rx;
      assign done = 1'b1;
    end else begin : g_drv
      initial begin
        logic [31:0] tmp;
        rstn = 1'b0; vin = 1'b0; rin = 1'b1; sgn = 1'b0; din = '0; done = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 20; k++) begin
          @(posedge clk); #1;
          vin = 1'b1;
          case (k)
            0: begin din = '0; sgn = 1'b0; end
            1: begin din = '0; sgn = 1'b1; end
            2: begin din = '1; sgn = 1'b0; end
            3: begin din = '1; sgn = 1'b1; end
            4: begin din = '0; din[WX-1] = 1'b1; sgn = 1'b1; end
            default: begin
              tmp = $urandom >> $urandom_range(0, 31);
              din = WX'(tmp);
              if ($urandom_range(0, 1) == 1) din = ~din;
              sgn = 1'($urandom_range(0, 1));
            end
          endcase
        end
        @(posedge clk); #1;
        vin = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk($sformatf("W%0d stream count", WX), rx, 20);
        done = 1'b1;
      end
    end

    // Scoreboard: push on in-transfer, pop and compare on out-transfer, check holds on stall.
    initial begin : g_mon
      exp_t        e;
      logic [41:0] prev;
      bit          stall;
      stall = 1'b0;
      prev  = '0;
      forever begin
        @(negedge clk);
        if (!rstn) begin
          eq.delete();
          stall = 1'b0;
        end else begin
          if (stall)
            chk($sformatf("W%0d stall hold", WX), {vout, 8'(cnt), 32'(nrm), zr}, prev);
          if (vout && rin) begin
            if (eq.size() == 0) begin
              chk($sformatf("W%0d unexpected result", WX), vout, 1'b0);
            end else begin
              e = eq.pop_front();
              chk($sformatf("W%0d result %0d", WX, rx), {8'(cnt), 32'(nrm), zr},
                  {8'(e.c), e.n, e.z});
            end
            rx++;
          end
          if (vin && rdy) eq.push_back(model(32'(din), sgn, WX));
          stall = vout && !rin;
          prev  = {vout, 8'(cnt), 32'(nrm), zr};
        end
      end
    end
  end

  task automatic send_one(input string nm, input logic [19:0] d, input bit s,
                          input int ec, input logic [19:0] en, input bit ez);
    @(posedge clk); #1;
    d0 = d; s0 = s; v0 = 1'b1;
    @(negedge clk);
    chk({nm, " accept"}, rdy0, 1'b1);
    @(posedge clk); #1;
    v0 = 1'b0;
    @(negedge clk);
    chk({nm, " not early"}, vld0, 1'b0);
    @(negedge clk);
    chk({nm, " valid"}, vld0, 1'b1);
    chk({nm, " count"}, cnt0, ec);
    chk({nm, " norm"}, nrm0, en);
    chk({nm, " zero"}, zr0, ez);
  endtask

  logic [19:0] dv[8] = '{20'h80000, 20'h00001, 20'h00123, 20'h00000,
                         20'h00123, 20'hFFC00, 20'hFFFFF, 20'h00000};
  bit          sv[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  int          cv[8] = '{0, 19, 11, 20, 10, 9, 19, 19};
  logic [19:0] nv[8] = '{20'h80000, 20'h80000, 20'h91800, 20'h00000,
                         20'h48C00, 20'h80000, 20'h80000, 20'h00000};
  bit          zv[8] = '{0, 0, 0, 1, 0, 0, 1, 1};

  initial begin
    exp_t        m;
    logic [19:0] tmp;
    int          rx_start;

    rst0 = 1'b0; v0 = 1'b0; r0 = 1'b1; d0 = '0; s0 = 1'b0;

    m = model(32'h00123, 1'b1, 20);
    chk("model signed 0x00123", {8'(m.c), m.n, m.z}, {8'd10, 32'h48C00, 1'b0});
    m = model(32'h00000, 1'b0, 20);
    chk("model unsigned zero", {8'(m.c), m.n, m.z}, {8'd20, 32'h0, 1'b1});
    m = model(32'hFFFF_FFFF, 1'b1, 32);
    chk("model signed ones W32", {8'(m.c), m.n, m.z}, {8'd31, 32'h8000_0000, 1'b1});

    @(negedge clk);
    chk("reset o_valid", vld0, 1'b0);
    chk("reset o_count", cnt0, 5'd0);
    chk("reset o_norm", nrm0, 20'd0);
    chk("reset o_zero", zr0, 1'b0);
    chk("reset o_ready", rdy0, 1'b1);
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    chk("post-reset o_ready", rdy0, 1'b1);

    for (int i = 0; i < 8; i++)
      send_one($sformatf("dir%0d", i), dv[i], sv[i], cv[i], nv[i], zv[i]);

    // Back-to-back: word i shows at the negedge two iterations later.
    rx_start = rx0;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      if (i < 16) begin
        tmp = 20'($urandom) >> $urandom_range(0, 19);
        if ($urandom_range(0, 1) == 1) tmp = ~tmp;
        d0 = tmp; s0 = 1'($urandom_range(0, 1)); v0 = 1'b1;
      end else begin
        v0 = 1'b0;
      end
      @(negedge clk);
      if (i < 16) chk($sformatf("b2b ready %0d", i), rdy0, 1'b1);
      if (i >= 2) chk($sformatf("b2b valid %0d", i - 2), vld0, 1'b1);
    end
    @(negedge clk);
    chk("b2b result count", rx0 - rx_start, 16);

    // Backpressure: two acceptances fill the pipe, then o_ready drops.
    rx_start = rx0;
    @(posedge clk); #1;
    r0 = 1'b0; v0 = 1'b1; d0 = 20'h00123; s0 = 1'b0;
    @(negedge clk);
    chk("bp accept 0", rdy0, 1'b1);
    @(posedge clk); #1;
    d0 = 20'hFFC00; s0 = 1'b1;
    @(negedge clk);
    chk("bp accept 1", rdy0, 1'b1);
    @(posedge clk); #1;
    d0 = 20'h00001; s0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp full ready %0d", i), rdy0, 1'b0);
      chk($sformatf("bp full valid %0d", i), vld0, 1'b1);
      @(posedge clk); #1;
    end
    r0 = 1'b1;
    #1 chk("bp release ready", rdy0, 1'b1);
    @(posedge clk); #1;
    d0 = 20'h80000; s0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("bp results delivered", rx0 - rx_start, 4);

    // Reset with both stages full.
    @(posedge clk); #1;
    r0 = 1'b0; v0 = 1'b1; d0 = 20'h11111; s0 = 1'b0;
    @(posedge clk); #1;
    d0 = 20'h02222;
    @(posedge clk); #1;
    v0 = 1'b0;
    chk("pre-reset full", vld0, 1'b1);
    #2 rst0 = 1'b0;
    #1;
    chk("async reset o_valid", vld0, 1'b0);
    chk("async reset o_count", cnt0, 5'd0);
    chk("async reset o_norm", nrm0, 20'd0);
    chk("async reset o_zero", zr0, 1'b0);
    chk("async reset o_ready", rdy0, 1'b1);
    r0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    chk("no stale after reset", vld0, 1'b0);
    send_one("post-reset 0x00040", 20'h00040, 1'b0, 13, 20'h80000, 1'b0);
    @(negedge clk);
    chk("single result only", vld0, 1'b0);

    for (int i = 0; i < 2000 && done_v != 5'h1F; i++) @(posedge clk);
    chk("width streams finished", done_v, 5'h1F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
